// File: rtl/mc_pkg.sv
// mc_pkg: shared constants for the multicycle MIPS control unit.
//   - FSM state encodings (fit in a 4-bit state register)
//   - opcode / funct field values
//   - ALU function codes and aluop codes
//   - is_retire_state(): states whose exit retires an instruction
package mc_pkg;

   // FSM state encodings (legacy-compatible numeric values)
   localparam logic [3:0] S_FETCH   = 4'd0;
   localparam logic [3:0] S_DECODE  = 4'd1;
   localparam logic [3:0] S_MEMADR  = 4'd2;
   localparam logic [3:0] S_MEMRD   = 4'd3;
   localparam logic [3:0] S_MEMWB   = 4'd4;
   localparam logic [3:0] S_MEMWR   = 4'd5;
   localparam logic [3:0] S_RTYPEEX = 4'd6;
   localparam logic [3:0] S_RTYPEWB = 4'd7;
   localparam logic [3:0] S_BEQEX   = 4'd8;
   localparam logic [3:0] S_ADDIEX  = 4'd9;
   localparam logic [3:0] S_ADDIWB  = 4'd10;
   localparam logic [3:0] S_JEX     = 4'd11;
   localparam logic [3:0] S_BNEEX   = 4'd12;

   // Opcodes, instr[31:26]
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BNE   = 6'b000101;

   // R-type funct codes, instr[5:0]
   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   // ALU function select
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   // aluop from the FSM to the ALU sub-decoder
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // Final states always return to FETCH, so leaving one retires an instruction.
   function automatic logic is_retire_state(input logic [3:0] s);
      return (s == S_MEMWB)   || (s == S_MEMWR)  || (s == S_RTYPEWB) ||
             (s == S_ADDIWB)  || (s == S_BEQEX)  || (s == S_JEX)     ||
             (s == S_BNEEX);
   endfunction

endpackage

// File: rtl/mc_controller_if.sv
// mc_controller_if: control-unit <-> datapath signal bundle.
//   master : control unit side (takes op/funct/zero/mem_ready, drives strobes)
//   slave  : datapath side (mirror image)
//   CNT_W  : width of the retired-instruction counter
interface mc_controller_if #(parameter int unsigned CNT_W = 32);
   logic [5:0]       op;
   logic [5:0]       funct;
   logic             zero;
   logic             mem_ready;
   logic [2:0]       alucontrol;
   logic             alusrca;
   logic [1:0]       alusrcb;
   logic [1:0]       pcsrc;
   logic             iord;
   logic             memtoreg;
   logic             regdst;
   logic             irwrite;
   logic             memwrite;
   logic             regwrite;
   logic             pcen;
   logic             illegal_op;
   logic [CNT_W-1:0] instr_count;

   modport master (
      input  op, funct, zero, mem_ready,
      output alucontrol, alusrca, alusrcb, pcsrc, iord, memtoreg, regdst,
             irwrite, memwrite, regwrite, pcen, illegal_op, instr_count
   );

   modport slave (
      output op, funct, zero, mem_ready,
      input  alucontrol, alusrca, alusrcb, pcsrc, iord, memtoreg, regdst,
             irwrite, memwrite, regwrite, pcen, illegal_op, instr_count
   );
endinterface

// File: rtl/mc_controller_alu_decoder.sv
// alu_decoder: maps aluop (from the FSM) and funct (instr[5:0]) to the
// 3-bit ALU function select. Purely combinational.
//   aluop_i      : 00 add, 01 sub, 10 decode funct
//   funct_i      : R-type funct field
//   alucontrol_o : ALU f code
module alu_decoder
   import mc_pkg::*;
(
   input  logic [1:0] aluop_i,
   input  logic [5:0] funct_i,
   output logic [2:0] alucontrol_o
);

   always_comb begin
      alucontrol_o = ALU_AND;
      case (aluop_i)
         ALUOP_ADD: alucontrol_o = ALU_ADD;
         ALUOP_SUB: alucontrol_o = ALU_SUB;
         default: begin
            case (funct_i)
               FN_ADD:  alucontrol_o = ALU_ADD;
               FN_SUB:  alucontrol_o = ALU_SUB;
               FN_AND:  alucontrol_o = ALU_AND;
               FN_OR:   alucontrol_o = ALU_OR;
               FN_SLT:  alucontrol_o = ALU_SLT;
               default: alucontrol_o = ALU_AND;
            endcase
         end
      endcase
   end

endmodule

// File: rtl/mc_controller.sv
// mc_controller: multicycle MIPS control unit (Moore FSM) with a memory-ready
// handshake and a retired-instruction counter.
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   bus      : mc_controller_if.master (op/funct/zero/mem_ready in; ALU select,
//              mux selects, write strobes, illegal_op, instr_count out)
// Parameters: STATE_W (state register width), CNT_W (counter width).
// Optional feature: define MC_CTRL_BNE_EN to add the BNE instruction (BNEEX).
module mc_controller
   import mc_pkg::*;
#(
   parameter int unsigned STATE_W = 4,
   parameter int unsigned CNT_W   = 32
) (
   input  logic           clk,
   input  logic           reset_n,
   mc_controller_if.master bus
);

   logic [STATE_W-1:0] state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               illegal_q, illegal_d;

   logic [1:0] aluop;
   logic       alusrca, iord, memtoreg, regdst;
   logic [1:0] alusrcb, pcsrc;
   logic       irwrite, memwrite, regwrite, pcwrite, branch;
`ifdef MC_CTRL_BNE_EN
   logic       bne;
`endif

   // Next-state logic
   always_comb begin
      state_d   = state_q;
      illegal_d = 1'b0;
      case (state_q)
         S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            case (bus.op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_RTYPEEX;
               OP_BEQ:       state_d = S_BEQEX;
               OP_ADDI:      state_d = S_ADDIEX;
               OP_J:         state_d = S_JEX;
`ifdef MC_CTRL_BNE_EN
               OP_BNE:       state_d = S_BNEEX;
`endif
               default: begin
                  state_d   = S_FETCH;
                  illegal_d = 1'b1;
               end
            endcase
         end
         S_MEMADR:  state_d = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:   if (bus.mem_ready) state_d = S_MEMWB;
         S_RTYPEEX: state_d = S_RTYPEWB;
         S_ADDIEX:  state_d = S_ADDIWB;
         default:   state_d = S_FETCH;
      endcase
   end

   // Moore outputs
   always_comb begin
      aluop    = ALUOP_ADD;
      alusrca  = 1'b0;
      alusrcb  = 2'b00;
      pcsrc    = 2'b00;
      iord     = 1'b0;
      memtoreg = 1'b0;
      regdst   = 1'b0;
      irwrite  = 1'b0;
      memwrite = 1'b0;
      regwrite = 1'b0;
      pcwrite  = 1'b0;
      branch   = 1'b0;
`ifdef MC_CTRL_BNE_EN
      bne      = 1'b0;
`endif
      case (state_q)
         S_FETCH: begin
            alusrcb = 2'b01;
            irwrite = bus.mem_ready;
            pcwrite = bus.mem_ready;
         end
         S_DECODE: alusrcb = 2'b11;
         S_MEMADR, S_ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         S_MEMRD: iord = 1'b1;
         S_MEMWB: begin
            memtoreg = 1'b1;
            regwrite = 1'b1;
         end
         S_MEMWR: begin
            iord     = 1'b1;
            memwrite = 1'b1;
         end
         S_RTYPEEX: begin
            alusrca = 1'b1;
            aluop   = ALUOP_FUNCT;
         end
         S_RTYPEWB: begin
            regdst   = 1'b1;
            regwrite = 1'b1;
         end
         S_BEQEX: begin
            alusrca = 1'b1;
            aluop   = ALUOP_SUB;
            pcsrc   = 2'b01;
            branch  = 1'b1;
         end
`ifdef MC_CTRL_BNE_EN
         S_BNEEX: begin
            alusrca = 1'b1;
            aluop   = ALUOP_SUB;
            pcsrc   = 2'b01;
            bne     = 1'b1;
         end
`endif
         S_ADDIWB: regwrite = 1'b1;
         S_JEX: begin
            pcsrc   = 2'b10;
            pcwrite = 1'b1;
         end
         default: ;
      endcase
   end

   alu_decoder u_alu_dec (
      .aluop_i      (aluop),
      .funct_i      (bus.funct),
      .alucontrol_o (bus.alucontrol)
   );

   // Counter advances when leaving a final state; the illegal-op return
   // leaves DECODE, which is not final, so it is never counted.
   always_comb begin
      cnt_d = cnt_q;
      if (is_retire_state(state_q)) cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_FETCH;
         cnt_q     <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         illegal_q <= illegal_d;
      end
   end

   assign bus.alusrca     = alusrca;
   assign bus.alusrcb     = alusrcb;
   assign bus.pcsrc       = pcsrc;
   assign bus.iord        = iord;
   assign bus.memtoreg    = memtoreg;
   assign bus.regdst      = regdst;
   // Write strobes are gated by reset_n so nothing fires while held in reset,
   // even though FETCH's strobes otherwise follow mem_ready combinationally.
   assign bus.irwrite     = reset_n & irwrite;
   assign bus.memwrite    = reset_n & memwrite;
   assign bus.regwrite    = reset_n & regwrite;
`ifdef MC_CTRL_BNE_EN
   assign bus.pcen        = reset_n & (pcwrite | (branch & bus.zero) | (bne & ~bus.zero));
`else
   assign bus.pcen        = reset_n & (pcwrite | (branch & bus.zero));
`endif
   assign bus.illegal_op  = illegal_q;
   assign bus.instr_count = cnt_q;

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: directed-vector bench for mc_controller (CNT_W=4 so the
// retired-instruction counter wrap is reachable quickly).
module tb_mc_controller;
   import mc_pkg::*;

   localparam int unsigned CW = 4;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   mc_controller_if #(.CNT_W(CW)) bus ();

   mc_controller #(.STATE_W(4), .CNT_W(CW)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   // {alusrca, alusrcb, pcsrc, iord, memtoreg, regdst, irwrite, memwrite, regwrite, pcen, alucontrol}
   logic [14:0] sig;
   assign sig = {bus.alusrca, bus.alusrcb, bus.pcsrc, bus.iord, bus.memtoreg, bus.regdst,
                 bus.irwrite, bus.memwrite, bus.regwrite, bus.pcen, bus.alucontrol};

   localparam logic [14:0] SIG_IDLE   = {1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010};
   localparam logic [14:0] SIG_GO     = {1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b010};
   localparam logic [14:0] SIG_DECODE = {1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010};
   localparam logic [14:0] SIG_MEMADR = {1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010};
   localparam logic [14:0] SIG_MEMRD  = {1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010};
   localparam logic [14:0] SIG_MEMWB  = {1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b010};
   localparam logic [14:0] SIG_MEMWR  = {1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b010};
   localparam logic [14:0] SIG_RWB    = {1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b010};
   localparam logic [14:0] SIG_ADDIWB = {1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b010};
   localparam logic [14:0] SIG_JEX    = {1'b0, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b010};

   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;
   logic [CW-1:0] exp_cnt = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Called one time unit after a rising edge with inputs already set.
   task automatic step(input string tag, input logic [14:0] exp);
      #1;
      check(tag, 32'(sig), 32'(exp));
      @(posedge clk); #1;
   endtask

   task automatic check_cnt(input string tag);
      check(tag, 32'(bus.instr_count), 32'(exp_cnt));
   endtask

   task automatic run_lw();
      bus.op = OP_LW;
      step("lw_fetch", SIG_GO);
      step("lw_decode", SIG_DECODE);
      step("lw_memadr", SIG_MEMADR);
      step("lw_memrd", SIG_MEMRD);
      step("lw_memwb", SIG_MEMWB);
      exp_cnt = exp_cnt + 1'b1;
      check_cnt("lw_cnt");
   endtask

   task automatic run_sw();
      bus.op = OP_SW;
      step("sw_fetch", SIG_GO);
      step("sw_decode", SIG_DECODE);
      step("sw_memadr", SIG_MEMADR);
      step("sw_memwr", SIG_MEMWR);
      exp_cnt = exp_cnt + 1'b1;
      check_cnt("sw_cnt");
   endtask

   task automatic run_r(input logic [5:0] fn, input logic [2:0] alu);
      bus.op = OP_RTYPE;
      bus.funct = fn;
      step("r_fetch", SIG_GO);
      step("r_decode", SIG_DECODE);
      step("r_ex", {1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, alu});
      step("r_wb", SIG_RWB);
      exp_cnt = exp_cnt + 1'b1;
      check_cnt("r_cnt");
   endtask

   task automatic run_beq(input logic z);
      bus.op = OP_BEQ;
      bus.zero = z;
      step("beq_fetch", SIG_GO);
      step("beq_decode", SIG_DECODE);
      step("beq_ex", {1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, z, 3'b110});
      bus.zero = 1'b0;
      exp_cnt = exp_cnt + 1'b1;
      check_cnt("beq_cnt");
   endtask

   task automatic run_addi();
      bus.op = OP_ADDI;
      step("addi_fetch", SIG_GO);
      step("addi_decode", SIG_DECODE);
      step("addi_ex", SIG_MEMADR);
      step("addi_wb", SIG_ADDIWB);
      exp_cnt = exp_cnt + 1'b1;
      check_cnt("addi_cnt");
   endtask

   task automatic run_j();
      bus.op = OP_J;
      step("j_fetch", SIG_GO);
      step("j_decode", SIG_DECODE);
      step("j_ex", SIG_JEX);
      exp_cnt = exp_cnt + 1'b1;
      check_cnt("j_cnt");
   endtask

   // Runs an opcode that must be rejected at DECODE.
   task automatic run_illegal(input logic [5:0] opc);
      bus.op = opc;
      step("ill_fetch", SIG_GO);
      step("ill_decode", SIG_DECODE);
      bus.mem_ready = 1'b0;           // park in FETCH so the pulse can be seen to end
      #1;
      check("ill_pulse", 32'(bus.illegal_op), 32'd1);
      check("ill_back_fetch", 32'(sig), 32'(SIG_IDLE));
      check_cnt("ill_cnt");
      @(posedge clk); #1;
      check("ill_clear", 32'(bus.illegal_op), 32'd0);
      check("ill_still_fetch", 32'(sig), 32'(SIG_IDLE));
      bus.mem_ready = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      reset_n       = 1'b0;
      bus.op        = OP_RTYPE;
      bus.funct     = 6'b000000;
      bus.zero      = 1'b0;
      bus.mem_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_sig", 32'(sig), 32'(SIG_IDLE));
      check("rst_cnt", 32'(bus.instr_count), 32'd0);
      check("rst_ill", 32'(bus.illegal_op), 32'd0);
      reset_n = 1'b1;

      run_lw();
      run_sw();
      run_r(FN_SLT, ALU_SLT);
      run_r(FN_ADD, ALU_ADD);
      run_r(FN_SUB, ALU_SUB);
      run_r(FN_AND, ALU_AND);
      run_r(FN_OR,  ALU_OR);
      run_r(6'b111111, 3'b000);
      run_beq(1'b1);
      run_beq(1'b0);
      run_addi();
      run_j();

      // FETCH stalls on mem_ready
      bus.op = OP_ADDI;
      bus.mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) step("stall_fetch", SIG_IDLE);
      bus.mem_ready = 1'b1;
      step("stall_go", SIG_GO);
      step("stall_decode", SIG_DECODE);
      step("stall_ex", SIG_MEMADR);
      step("stall_wb", SIG_ADDIWB);
      exp_cnt = exp_cnt + 1'b1;
      check_cnt("stall_cnt");

      run_illegal(6'b111111);

`ifdef MC_CTRL_BNE_EN
      bus.op = OP_BNE;
      bus.zero = 1'b0;
      step("bne_fetch", SIG_GO);
      step("bne_decode", SIG_DECODE);
      step("bne_ex", {1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b110});
      exp_cnt = exp_cnt + 1'b1;
      check_cnt("bne_cnt");
`else
      run_illegal(OP_BNE);
`endif

      // MEMRD waits for mem_ready
      bus.op = OP_LW;
      step("lwst_fetch", SIG_GO);
      step("lwst_decode", SIG_DECODE);
      step("lwst_memadr", SIG_MEMADR);
      bus.mem_ready = 1'b0;
      step("lwst_wait0", SIG_MEMRD);
      step("lwst_wait1", SIG_MEMRD);
      bus.mem_ready = 1'b1;
      step("lwst_memrd", SIG_MEMRD);
      step("lwst_memwb", SIG_MEMWB);
      exp_cnt = exp_cnt + 1'b1;
      check_cnt("lwst_cnt");

      // Counter wrap: climb to all-ones, then one more retirement gives zero
      while (exp_cnt != '1) run_addi();
      check("wrap_ones", 32'(bus.instr_count), 32'hF);
      run_addi();
      check("wrap_zero", 32'(bus.instr_count), 32'h0);
      for (int i = 0; i < 16; i++) run_addi();
      check("wrap_full_cycle", 32'(bus.instr_count), 32'h0);

      // Async reset in the middle of RTYPEEX
      bus.op = OP_RTYPE;
      bus.funct = FN_SLT;
      step("mid_fetch", SIG_GO);
      step("mid_decode", SIG_DECODE);
      bus.zero = 1'b1;
      #1;
      check("mid_ex", 32'(sig), 32'({1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b111}));
      reset_n = 1'b0;
      #1;
      check("mid_rst_sig", 32'(sig), 32'(SIG_IDLE));
      check("mid_rst_cnt", 32'(bus.instr_count), 32'd0);
      check("mid_rst_ill", 32'(bus.illegal_op), 32'd0);
      @(posedge clk); #1;
      check("mid_rst_hold", 32'(sig), 32'(SIG_IDLE));
      reset_n = 1'b1;
      bus.zero = 1'b0;
      exp_cnt = '0;
      step("mid_after_fetch", SIG_GO);
      step("mid_after_decode", SIG_DECODE);
      check_cnt("mid_after_cnt");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
